arm_imm_encoder: RTL and testbench

- Inverse of the execute-stage Val2 immediate path: takes a 32-bit constant and searches for the ARM data-processing immediate encoding {rotate_imm[3:0], imm8[7:0]} such that value == imm8 ROR (2*rotate_imm).
- Sits beside the instruction-memory loader / test-program builder; feeds a 12-bit Shift_operand plus an encodable flag back to the instruction assembler.
- Multi-cycle rotation search with valid/ready handshakes on both sides.

---
 rtl/arm_pkg.sv | 20 ++
 rtl/arm_imm_encoder_if.sv | 21 ++
 rtl/arm_imm_rot_check.sv | 15 +
 rtl/arm_imm_encoder.sv | 147 ++++++++++++++
 tb/tb_arm_imm_encoder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared types and helpers for the ARM immediate encoder: field widths, FSM state enum, rotate-left.
package arm_pkg;
  localparam int SHIFT_OPERAND_W = 12;
  localparam int ROT_W           = 4;
  localparam int IMM8_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } enc_state_t;

  // A zero amount returns the value untouched so no path ever shifts by 32.
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] sh);
    logic [5:0] back;
    back = 6'd32 - {1'b0, sh};
    if (sh == 5'd0) return v;
    return (v << sh) | (v >> back);
  endfunction
endpackage

// File: rtl/arm_imm_encoder_if.sv
// Request/result handshake bundle between the instruction assembler and the immediate encoder.
interface arm_imm_encoder_if;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [31:0]                          in_value;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_found;
  logic [arm_pkg::SHIFT_OPERAND_W-1:0]  out_shift_operand;
  logic                                 out_inverted;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_found, out_shift_operand, out_inverted
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_found, out_shift_operand, out_inverted
  );
endinterface

// File: rtl/arm_imm_rot_check.sv
// One rotation lane: does value ROL 2*rot fit in eight bits, and what is that byte.
module arm_imm_rot_check
  import arm_pkg::*;
(
  input  logic [31:0]       value,
  input  logic [ROT_W-1:0]  rot,
  output logic              hit,
  output logic [IMM8_W-1:0] imm8
);
  logic [31:0] rotated;

  assign rotated = rol32(value, {rot, 1'b0});
  assign hit     = (rotated[31:8] == 24'd0);
  assign imm8    = rotated[7:0];
endmodule

// File: rtl/arm_imm_encoder.sv
// Multi-cycle search for the ARM {rotate_imm, imm8} encoding of a 32-bit constant.
// Optional second pass on the inverted value when ARM_IMM_ENC_INVERT_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request, in_ready high
// SEARCH | testing CHECKS_PER_CYCLE rotations per cycle, group by group
// DONE   | result presented with out_valid until out_ready
module arm_imm_encoder
  import arm_pkg::*;
#(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  arm_imm_encoder_if.slave  bus
);
  localparam int               NUM_GROUPS = 16 / CHECKS_PER_CYCLE;
  localparam logic [ROT_W-1:0] LAST_GROUP = ROT_W'(NUM_GROUPS - 1);

  enc_state_t                 state, state_nxt;
  logic [31:0]                value_q;
  logic [31:0]                test_value;
  logic [ROT_W-1:0]           group;
  logic                       found_q;
  logic [SHIFT_OPERAND_W-1:0] shift_q;
  logic                       inverted_q;
  logic                       pass;
  logic                       final_pass;

  logic [CHECKS_PER_CYCLE-1:0] lane_hit;
  logic [ROT_W-1:0]            lane_rot [CHECKS_PER_CYCLE];
  logic [IMM8_W-1:0]           lane_imm [CHECKS_PER_CYCLE];
  logic                        any_hit;
  logic [ROT_W-1:0]            sel_rot;
  logic [IMM8_W-1:0]           sel_imm;

`ifdef ARM_IMM_ENC_INVERT_EN
  logic pass_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else if (state == ST_IDLE && bus.in_valid) begin
      pass_q <= 1'b0;
    end else if (state == ST_SEARCH && !any_hit && group == LAST_GROUP && !pass_q) begin
      pass_q <= 1'b1;
    end
  end

  assign pass       = pass_q;
  assign final_pass = pass_q;
`else
  assign pass       = 1'b0;
  assign final_pass = 1'b1;
`endif

  assign test_value = pass ? ~value_q : value_q;

  for (genvar i = 0; i < CHECKS_PER_CYCLE; i++) begin : g_lane
    assign lane_rot[i] = group * ROT_W'(CHECKS_PER_CYCLE) + ROT_W'(i);
    arm_imm_rot_check u_chk (
      .value (test_value),
      .rot   (lane_rot[i]),
      .hit   (lane_hit[i]),
      .imm8  (lane_imm[i])
    );
  end

  // Walk lanes high to low so the lowest hitting rotation is the one left standing.
  always_comb begin
    any_hit = 1'b0;
    sel_rot = '0;
    sel_imm = '0;
    for (int i = CHECKS_PER_CYCLE - 1; i >= 0; i--) begin
      if (lane_hit[i]) begin
        any_hit = 1'b1;
        sel_rot = lane_rot[i];
        sel_imm = lane_imm[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.in_valid) state_nxt = ST_SEARCH;
      ST_SEARCH: if (any_hit || (group == LAST_GROUP && final_pass)) state_nxt = ST_DONE;
      ST_DONE:   if (bus.out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ST_IDLE: bus.in_ready  = 1'b1;
      ST_DONE: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q    <= '0;
      group      <= '0;
      found_q    <= 1'b0;
      shift_q    <= '0;
      inverted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            value_q <= bus.in_value;
            group   <= '0;
          end
        end
        ST_SEARCH: begin
          if (any_hit) begin
            found_q    <= 1'b1;
            shift_q    <= {sel_rot, sel_imm};
            inverted_q <= pass;
          end else if (group == LAST_GROUP) begin
            group <= '0;
            if (final_pass) begin
              found_q    <= 1'b0;
              shift_q    <= '0;
              inverted_q <= 1'b0;
            end
          end else begin
            group <= group + ROT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_found         = found_q;
  assign bus.out_shift_operand = shift_q;
  assign bus.out_inverted      = inverted_q;
endmodule

// File: tb/tb_arm_imm_encoder.sv
// Bench for arm_imm_encoder: one instance with 1 check/cycle and one with 4, driven in lockstep.
module tb_arm_imm_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

`ifdef ARM_IMM_ENC_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  arm_imm_encoder_if bus1 ();
  arm_imm_encoder_if bus4 ();

  arm_imm_encoder #(.CHECKS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  arm_imm_encoder #(.CHECKS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    bit          found;
    bit          inv;
    logic [11:0] so;
    int          lat;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Smallest r whose rotate-left by 2r leaves a value below 256.
  function automatic int first_hit(input logic [31:0] v, output logic [7:0] imm);
    logic [31:0] t;
    t   = v;
    imm = 8'h00;
    for (int r = 0; r < 16; r++) begin
      if (t < 32'd256) begin
        imm = t[7:0];
        return r;
      end
      t = (t << 2) | (t >> 30);
    end
    return -1;
  endfunction

  // lat = clock edges after the accepting edge until out_valid is seen.
  function automatic exp_t model(input logic [31:0] v, input int n);
    exp_t        e;
    int          h;
    int          ng;
    logic [7:0]  imm;
    ng      = 16 / n;
    e.found = 1'b0;
    e.inv   = 1'b0;
    e.so    = 12'h000;
    e.lat   = ng;
    h = first_hit(v, imm);
    if (h >= 0) begin
      e.found = 1'b1;
      e.so    = {4'(h), imm};
      e.lat   = h / n + 1;
      return e;
    end
    if (INV_EN) begin
      e.lat = 2 * ng;
      h = first_hit(~v, imm);
      if (h >= 0) begin
        e.found = 1'b1;
        e.inv   = 1'b1;
        e.so    = {4'(h), imm};
        e.lat   = ng + h / n + 1;
      end
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] v);
    @(negedge clk);
    check("pre.rdy1", 32'(bus1.in_ready), 32'd1);
    check("pre.rdy4", 32'(bus4.in_ready), 32'd1);
    bus1.in_valid = 1'b1;  bus1.in_value = v;
    bus4.in_valid = 1'b1;  bus4.in_value = v;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] v, input string name);
    exp_t        e1, e4;
    int          lat1, lat4;
    bit          d1, d4;
    logic        f1, i1, f4, i4;
    logic [11:0] s1, s4;
    e1 = model(v, 1);
    e4 = model(v, 4);
    lat1 = -1; lat4 = -1; d1 = 1'b0; d4 = 1'b0;
    f1 = 1'b0; i1 = 1'b0; s1 = '0; f4 = 1'b0; i4 = 1'b0; s4 = '0;
    bus1.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    issue(v);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({name, ".busy1"}, 32'(bus1.in_ready), 32'd0);
        check({name, ".busy4"}, 32'(bus4.in_ready), 32'd0);
        bus1.in_valid = 1'b1;  bus1.in_value = ~v ^ 32'h5A5A_0F0F;
        bus4.in_valid = 1'b1;  bus4.in_value = ~v ^ 32'h5A5A_0F0F;
      end
      if (k == 2) begin
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
      end
      if (!d1 && bus1.out_valid === 1'b1) begin
        d1 = 1'b1; lat1 = k;
        f1 = bus1.out_found; i1 = bus1.out_inverted; s1 = bus1.out_shift_operand;
      end else if (d1 && k == lat1 + 1) begin
        check({name, ".vld1_drop"}, 32'(bus1.out_valid), 32'd0);
        check({name, ".rdy1_back"}, 32'(bus1.in_ready), 32'd1);
      end
      if (!d4 && bus4.out_valid === 1'b1) begin
        d4 = 1'b1; lat4 = k;
        f4 = bus4.out_found; i4 = bus4.out_inverted; s4 = bus4.out_shift_operand;
      end else if (d4 && k == lat4 + 1) begin
        check({name, ".vld4_drop"}, 32'(bus4.out_valid), 32'd0);
        check({name, ".rdy4_back"}, 32'(bus4.in_ready), 32'd1);
      end
      if (d1 && d4 && k >= lat1 + 1 && k >= lat4 + 1) break;
    end
    check({name, ".done1"}, 32'(d1), 32'd1);
    check({name, ".done4"}, 32'(d4), 32'd1);
    check({name, ".found1"}, 32'(f1), 32'(e1.found));
    check({name, ".so1"},    32'(s1), 32'(e1.so));
    check({name, ".inv1"},   32'(i1), 32'(e1.inv));
    check({name, ".lat1"},   lat1,    e1.lat);
    check({name, ".found4"}, 32'(f4), 32'(e4.found));
    check({name, ".so4"},    32'(s4), 32'(e4.so));
    check({name, ".inv4"},   32'(i4), 32'(e4.inv));
    check({name, ".lat4"},   lat4,    e4.lat);
  endtask

  task automatic hold_test(input logic [31:0] v);
    exp_t e1, e4;
    e1 = model(v, 1);
    e4 = model(v, 4);
    bus1.out_ready = 1'b0;
    bus4.out_ready = 1'b0;
    issue(v);
    for (int k = 0; k < 40; k++) begin
      if (bus1.out_valid === 1'b1 && bus4.out_valid === 1'b1) break;
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      check("hold.vld1", 32'(bus1.out_valid), 32'd1);
      check("hold.rdy1", 32'(bus1.in_ready), 32'd0);
      check("hold.so1",  32'(bus1.out_shift_operand), 32'(e1.so));
      check("hold.vld4", 32'(bus4.out_valid), 32'd1);
      check("hold.rdy4", 32'(bus4.in_ready), 32'd0);
      check("hold.so4",  32'(bus4.out_shift_operand), 32'(e4.so));
      @(negedge clk);
    end
    bus1.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("hold.rel1", 32'(bus1.out_valid), 32'd0);
    check("hold.rel4", 32'(bus4.out_valid), 32'd0);
  endtask

  task automatic reset_mid_search();
    int rises;
    bus1.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    issue(32'h0000_0102);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst.vld1", 32'(bus1.out_valid), 32'd0);
    check("rst.rdy1", 32'(bus1.in_ready), 32'd1);
    check("rst.vld4", 32'(bus4.out_valid), 32'd0);
    check("rst.rdy4", 32'(bus4.in_ready), 32'd1);
    rises = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus1.out_valid !== 1'b0 || bus4.out_valid !== 1'b0) rises++;
    end
    check("rst.dropped", rises, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] x;
    int          r;
    rst_n = 1'b0;
    bus1.in_valid = 1'b0;  bus1.in_value = '0;  bus1.out_ready = 1'b1;
    bus4.in_valid = 1'b0;  bus4.in_value = '0;  bus4.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.rdy1",   32'(bus1.in_ready), 32'd1);
    check("reset.vld1",   32'(bus1.out_valid), 32'd0);
    check("reset.found1", 32'(bus1.out_found), 32'd0);
    check("reset.so1",    32'(bus1.out_shift_operand), 32'd0);
    check("reset.inv1",   32'(bus1.out_inverted), 32'd0);
    check("reset.rdy4",   32'(bus4.in_ready), 32'd1);
    check("reset.vld4",   32'(bus4.out_valid), 32'd0);
    rst_n = 1'b1;

    run(32'h0000_00FF, "imm_ff");
    run(32'hFF00_0000, "ff_top");
    run(32'hF000_000F, "wrap");
    run(32'h0000_0102, "miss");
    run(32'hFFFF_FF00, "inv_cand");
    run(32'h0000_0000, "zero");
    run(32'h0000_03FC, "rot15");
    run(32'h8000_0001, "rot1");
    run(32'hFFFF_FFFF, "ones");

    hold_test(32'hFF00_0000);
    reset_mid_search();
    run(32'h0000_00FF, "after_rst");

    for (int i = 0; i < 30; i++) begin
      x = 32'($urandom_range(0, 255));
      r = 2 * int'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = (x >> r) | (x << (32 - r));
        2: v = ~((x >> r) | (x << (32 - r)));
        default: v = x << $urandom_range(0, 24);
      endcase
      run(v, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
